// File: rtl/rvfi_retire_serializer.sv
// rtl/rvfi_retire_serializer.sv - buffers multi-channel RVFI retirements and replays them one per cycle
//
// Purpose: lets one single-channel instruction checker follow an NRET-wide
// retiring core. Each cycle, the valid retire channels are compacted in
// ascending channel order into a circular buffer. They are then presented one
// entry per cycle on a valid/ready port.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   enable                 capture qualifier; rvfi_valid ignored when 0
//   rvfi_valid/order/pkt   NRET retire channels, channel i in slice i
//   in_ready               at least NRET free entries (informational; never stalls)
//   out_valid/out_ready    head handshake
//   out_order/out_pkt      head entry, zero when empty
//   level                  occupied entries
//   overflow               sticky: a cycle's retirements were dropped
//   order_err              sticky: popped orders not consecutive
//
// Optional feature: define RVFI_SERIALIZER_ORDER_CHECK_EN to enable the
// popped-order continuity check; otherwise order_err is tied to 0.

module rvfi_retire_serializer #(
  parameter int NRET    = 2,
  parameter int ORDER_W = 8,
  parameter int PKT_W   = 256,
  parameter int DEPTH   = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      enable,
  input  logic [NRET-1:0]           rvfi_valid,
  input  logic [NRET*ORDER_W-1:0]   rvfi_order,
  input  logic [NRET*PKT_W-1:0]     rvfi_pkt,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ORDER_W-1:0]        out_order,
  output logic [PKT_W-1:0]          out_pkt,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic                      order_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(NRET + 1);

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ORDER_W-1:0] mem_order [DEPTH];
  logic [PKT_W-1:0]   mem_pkt   [DEPTH];

  logic [CNT_W-1:0]   n;
  logic [CNT_W-1:0]   ch_off [NRET];
  logic [PTR_W-1:0]   wr_idx [NRET];
  logic               pop;
  logic               push_ok;
  logic [LVL_W-1:0]   n_acc;

  // Compaction: each valid channel's slot is wr_ptr plus the number of
  // valid channels below it, so channel 0 always lands first.
  always_comb begin
    n = '0;
    for (int i = 0; i < NRET; i++) begin
      ch_off[i] = n;
      wr_idx[i] = wr_ptr + PTR_W'(ch_off[i]);
      if (enable && rvfi_valid[i]) begin
        n = n + CNT_W'(1);
      end
    end
  end

  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;

  // n <= DEPTH - level + pop, rearranged to avoid unsigned underflow.
  // A rejected cycle is dropped whole, never partially.
  assign push_ok = (32'(n) + 32'(level)) <= (32'(DEPTH) + 32'(pop));
  assign n_acc   = push_ok ? LVL_W'(n) : '0;

  assign in_ready  = (32'(level) + 32'(NRET)) <= 32'(DEPTH);
  assign out_order = out_valid ? mem_order[rd_ptr] : '0;
  assign out_pkt   = out_valid ? mem_pkt[rd_ptr]   : '0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(n);
      end else begin
        overflow <= 1'b1;
      end
      level <= level + n_acc - LVL_W'(pop);
    end
  end

  // Storage is not reset; level alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (resetn && push_ok) begin
      for (int i = 0; i < NRET; i++) begin
        if (enable && rvfi_valid[i]) begin
          mem_order[wr_idx[i]] <= rvfi_order[i*ORDER_W +: ORDER_W];
          mem_pkt[wr_idx[i]]   <= rvfi_pkt[i*PKT_W +: PKT_W];
        end
      end
    end
  end

`ifdef RVFI_SERIALIZER_ORDER_CHECK_EN
  logic [ORDER_W-1:0] exp_order;
  logic               seen_first;

  // The first popped order seeds the expectation; later pops must follow it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      exp_order  <= '0;
      seen_first <= 1'b0;
      order_err  <= 1'b0;
    end else if (pop) begin
      seen_first <= 1'b1;
      exp_order  <= out_order + ORDER_W'(1);
      if (seen_first && (out_order != exp_order)) begin
        order_err <= 1'b1;
      end
    end
  end
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// tb/tb_rvfi_retire_serializer.sv - scoreboard bench for rvfi_retire_serializer

module tb_rvfi_retire_serializer;

  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         enable = 1'b0;
  logic [1:0]   rvfi_valid = '0;
  logic [15:0]  rvfi_order = '0;
  logic [511:0] rvfi_pkt = '0;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   out_order;
  logic [255:0] out_pkt;
  logic [3:0]   level;
  logic         overflow;
  logic         order_err;

  rvfi_retire_serializer #(
    .NRET(2), .ORDER_W(8), .PKT_W(256), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_pkt(rvfi_pkt),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_order(out_order), .out_pkt(out_pkt), .level(level),
    .overflow(overflow), .order_err(order_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]   order;
    logic [255:0] pkt;
  } ent_t;

  ent_t       q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic       ov_exp = 1'b0;
  logic       err_exp = 1'b0;
  logic       seen_exp = 1'b0;
  logic [7:0] nxt_exp = '0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_pkt();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_state();
    chk("out_valid", 256'(out_valid), 256'(q.size() != 0));
    chk("level", 256'(level), 256'(q.size()));
    chk("in_ready", 256'(in_ready), 256'((DEPTH - q.size()) >= 2));
    chk("overflow", 256'(overflow), 256'(ov_exp));
    chk("order_err", 256'(order_err), 256'(err_exp));
    if (q.size() != 0) begin
      chk("out_order", 256'(out_order), 256'(q[0].order));
      chk("out_pkt", out_pkt, q[0].pkt);
    end else begin
      chk("out_order_empty", 256'(out_order), 256'(0));
      chk("out_pkt_empty", out_pkt, 256'(0));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; enable = 1'b1; rvfi_valid = 2'b11; out_ready = 1'b1;
    rvfi_order = {8'd2, 8'd1}; rvfi_pkt = {rand_pkt(), rand_pkt()};
    @(negedge clk);
    @(negedge clk);
    #1;
    q.delete(); ov_exp = 1'b0; err_exp = 1'b0; seen_exp = 1'b0; nxt_exp = '0;
    check_state();
  endtask

  // One cycle: drive at negedge, check the pre-edge state, then advance the model.
  task automatic step(input logic en, input logic [1:0] v, input logic [7:0] o0,
                      input logic [7:0] o1, input logic rdy);
    logic [255:0] p0, p1;
    int n, sz, popc;
    ent_t e;
    p0 = rand_pkt(); p1 = rand_pkt();
    @(negedge clk);
    resetn = 1'b1; enable = en; rvfi_valid = v; out_ready = rdy;
    rvfi_order = {o1, o0}; rvfi_pkt = {p1, p0};
    #1;
    check_state();
    sz   = q.size();
    popc = (rdy && sz != 0) ? 1 : 0;
    n    = en ? (int'(v[0]) + int'(v[1])) : 0;
    if (popc == 1) begin
      e = q.pop_front();
`ifdef RVFI_SERIALIZER_ORDER_CHECK_EN
      if (seen_exp && e.order != nxt_exp) err_exp = 1'b1;
      seen_exp = 1'b1;
      nxt_exp  = e.order + 8'd1;
`endif
    end
    if (n > DEPTH - sz + popc) begin
      ov_exp = 1'b1;
    end else begin
      if (en && v[0]) q.push_back('{order: o0, pkt: p0});
      if (en && v[1]) q.push_back('{order: o1, pkt: p1});
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() != 0; k++) step(1'b1, 2'b00, 8'd0, 8'd0, 1'b1);
    step(1'b1, 2'b00, 8'd0, 8'd0, 1'b1);
  endtask

  initial begin
    logic [7:0] nxt;
    int sent, room, k, popc;
    logic rdy;
    logic [1:0] v;
    logic [7:0] o0, o1;

    // Reset with both channels valid
    do_reset();

    // Dual retire 5,6, then enable=0 ignores valid channels
    step(1'b1, 2'b11, 8'd5, 8'd6, 1'b1);
    step(1'b1, 2'b00, 8'd0, 8'd0, 1'b1);
    step(1'b1, 2'b00, 8'd0, 8'd0, 1'b1);
    step(1'b0, 2'b11, 8'd7, 8'd8, 1'b1);
    step(1'b1, 2'b00, 8'd0, 8'd0, 1'b1);

    // Sparse: only channel 1
    do_reset();
    step(1'b1, 2'b10, 8'd0, 8'd9, 1'b0);
    step(1'b1, 2'b00, 8'd0, 8'd0, 1'b0);
    drain();

    // Fill, overflow, pop-and-push at full
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 2'b11, 8'(10 + 2*i), 8'(11 + 2*i), 1'b0);
    step(1'b1, 2'b11, 8'd18, 8'd19, 1'b0);
    step(1'b1, 2'b01, 8'd18, 8'd0, 1'b1);
    step(1'b1, 2'b00, 8'd0, 8'd0, 1'b0);
    drain();

    // Wrap: 20 consecutive orders from 250 with random out_ready
    do_reset();
    nxt = 8'd250;
    sent = 0;
    for (int it = 0; it < 200; it++) begin
      if (sent >= 20 && q.size() == 0) break;
      rdy  = 1'($urandom_range(0, 1));
      popc = (rdy && q.size() != 0) ? 1 : 0;
      room = DEPTH - q.size() + popc;
      k = $urandom_range(0, 2);
      if (k > 20 - sent) k = 20 - sent;
      if (k > room) k = room;
      o0 = 8'd0; o1 = 8'd0; v = 2'b00;
      if (k == 2) begin
        v = 2'b11; o0 = nxt; o1 = nxt + 8'd1;
      end else if (k == 1) begin
        if ($urandom_range(0, 1) == 0) begin v = 2'b01; o0 = nxt; end
        else begin v = 2'b10; o1 = nxt; end
      end
      step(1'b1, v, o0, o1, rdy);
      nxt  = nxt + 8'(k);
      sent = sent + k;
    end
    drain();
    chk("wrap_next_order", 256'(nxt), 256'(8'd14));

    // Order gap 3 -> 5
    do_reset();
    step(1'b1, 2'b01, 8'd3, 8'd0, 1'b0);
    step(1'b1, 2'b01, 8'd5, 8'd0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
